bldcm_pwm_capture: RTL and testbench
====================================

Name: bldcm_pwm_capture

Overview:
Measures an incoming PWM waveform: high time and period, in system clock cycles. It is the receive-side counterpart of the PWM generator. Typical uses are decoding a speed-command PWM from a host or RC receiver, and loop-back checking of the motor driver's own PWM outputs. Results are published on a one-cycle valid strobe per complete period. A timeout flag covers stuck-high and stuck-low inputs.

Parameters:
pCounterWidth, 32, width of cycle counters and of all count ports
pSyncStages, 2, number of synchronizer flip-flops on iPwm (minimum 2)
pFilterLen, 4, cycles of required input stability (used only with the optional filter)

Ports:
iClock  input  1  system clock; the only clock (one clock domain)
iReset  input  1  reset; asynchronous, active-high
iEnable  input  1  capture enable; low forces IDLE
iPwm  input  1  asynchronous PWM input
iTimeout  input  pCounterWidth  edge timeout in cycles; 0 = timeout disabled
oHighCnt  output  pCounterWidth  last measured high time, in cycles
oPeriodCnt  output  pCounterWidth  last measured period (rise to rise), in cycles
oValid  output  1  one-cycle strobe when oHighCnt/oPeriodCnt update
oTimeout  output  1  sticky: no rising edge within iTimeout cycles
oLevel  output  1  current synchronized (filtered) input level

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. All registers clear. oHighCnt=0, oPeriodCnt=0, oValid=0, oTimeout=0, oLevel=0, state=IDLE.
- Synchronizer: iPwm passes through pSyncStages flip-flops to give sPwm; oLevel = sPwm.
- Edge detect: rise = sPwm & ~prev, fall = ~sPwm & prev. prev updates every cycle.
- Edge latency: an edge on the pin is detected pSyncStages+1 cycles later. Measurements are unaffected because both edges see the same delay.
- Counter rCnt:
  - loads 1 in the cycle a rise is detected;
  - otherwise increments each cycle while in HIGH or LOW;
  - saturates at all-ones and never wraps.
- State machine:
  - IDLE: rCnt=0. On rise (with iEnable=1) -> HIGH. The first partial period is never reported.
  - HIGH: on fall, rHigh <= rCnt, then -> LOW. A rise cannot occur in HIGH.
  - LOW: on rise, oPeriodCnt <= rCnt, oHighCnt <= rHigh, oValid=1 on the next cycle, oTimeout <= 0, rCnt <= 1, then -> HIGH.
- Worked example: high 3 cycles, period 10 -> oHighCnt=3, oPeriodCnt=10.
- Timeout:
  - Applies in HIGH or LOW when iTimeout!=0 and rCnt >= iTimeout with no rise in that cycle.
  - Response: oTimeout <= 1, state -> IDLE.
  - oHighCnt and oPeriodCnt hold their old values.
  - If a rise and the timeout condition occur in the same cycle, the rise wins.
- Saturated count: if rCnt has saturated, the reported value is all-ones. No error flag is raised.
- iEnable=0:
  - state -> IDLE within 1 cycle; rCnt cleared; oValid=0.
  - oHighCnt, oPeriodCnt and oTimeout hold their values.
  - The synchronizer keeps running, so oLevel stays live.
- iEnable deasserted mid-period: the partial measurement is discarded. On re-enable, a full rise-to-rise period is required before the next oValid.
- iTimeout changes take effect immediately; they are compared every cycle.
- Asserting iReset mid-measurement returns every register to its reset value immediately.

Optional Feature:
Macro BLDCM_PWMCAP_FILTER_EN.
- Defined: a glitch filter sits between sPwm and the edge detector. The filtered level changes only after sPwm holds the new value for pFilterLen consecutive cycles. Pulses shorter than pFilterLen cycles are ignored entirely. Edge latency grows by pFilterLen cycles. oLevel shows the filtered level.
- Not defined: no filter. Every synchronized transition is an edge, and pFilterLen is unused.

Test Plan:
- Reset asserted asynchronously mid-period (between clock edges) -> all outputs 0 immediately; state IDLE; no oValid until two rises after release.
- iEnable=1, iTimeout=0, continuous PWM high 3/period 10 -> first oValid after the 2nd rise with oHighCnt=3, oPeriodCnt=10; oValid pulses exactly one cycle, every 10 cycles.
- PWM high 250/period 1000, then switched to high 700/period 1000 -> reports 250/1000, then exactly one transitional report, then 700/1000.
- iTimeout=50, input stuck low after a valid 5/20 measurement -> oTimeout=1 exactly 50 cycles after the last rise; oHighCnt=5 and oPeriodCnt=20 hold; the next two rises clear oTimeout with a fresh report.
- Rise coinciding with rCnt==iTimeout (period 50, iTimeout=50) -> oValid with oPeriodCnt=50; oTimeout stays 0.
- With BLDCM_PWMCAP_FILTER_EN, pFilterLen=4: a 2-cycle glitch inside the low phase of PWM 10/40 -> ignored, report 10/40. Without the macro, the same glitch produces a spurious report with oPeriodCnt<40.

Source files
------------

// File: rtl/bldcm_pwm_capture.sv
// PWM capture: measures high time and rise-to-rise period of iPwm in iClock cycles.
// Optional glitch filter enabled by defining BLDCM_PWMCAP_FILTER_EN.
module bldcm_pwm_capture #(
   parameter int unsigned pCounterWidth = 32,
   parameter int unsigned pSyncStages   = 2,
   parameter int unsigned pFilterLen    = 4
) (
   input  logic                     iClock,
   input  logic                     iReset,
   input  logic                     iEnable,
   input  logic                     iPwm,
   input  logic [pCounterWidth-1:0] iTimeout,
   output logic [pCounterWidth-1:0] oHighCnt,
   output logic [pCounterWidth-1:0] oPeriodCnt,
   output logic                     oValid,
   output logic                     oTimeout,
   output logic                     oLevel
);

   typedef enum logic [1:0] {IDLE, HIGH, LOW} tState;

   localparam logic [pCounterWidth-1:0] cOne = pCounterWidth'(1);

   if (pSyncStages < 2 || pFilterLen < 1) begin : gParamCheck
      $error("bldcm_pwm_capture: pSyncStages must be >= 2 and pFilterLen >= 1");
   end

   logic [pSyncStages-1:0] rSync;
   logic                   sPwm;
   logic                   level;
   logic                   rPrev;
   logic                   rise;
   logic                   fall;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) rSync <= '0;
      else        rSync <= {rSync[pSyncStages-2:0], iPwm};
   end

   assign sPwm = rSync[pSyncStages-1];

`ifdef BLDCM_PWMCAP_FILTER_EN
   localparam int unsigned cFiltW = $clog2(pFilterLen + 1);

   logic [cFiltW-1:0] rFiltCnt;
   logic              rFilt;

   // The filtered level follows sPwm only once it has disagreed for pFilterLen straight cycles.
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         rFilt    <= 1'b0;
         rFiltCnt <= '0;
      end else if (sPwm == rFilt) begin
         rFiltCnt <= '0;
      end else if (rFiltCnt == cFiltW'(pFilterLen - 1)) begin
         rFilt    <= sPwm;
         rFiltCnt <= '0;
      end else begin
         rFiltCnt <= rFiltCnt + 1'b1;
      end
   end

   assign level = rFilt;
`else
   assign level = sPwm;
`endif

   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) rPrev <= 1'b0;
      else        rPrev <= level;
   end

   assign rise   = level & ~rPrev;
   assign fall   = ~level & rPrev;
   assign oLevel = level;

   tState                    rState, nState;
   logic [pCounterWidth-1:0] rCnt, nCnt, cntInc;
   logic [pCounterWidth-1:0] rHigh, nHigh;
   logic [pCounterWidth-1:0] nHighOut, nPeriodOut;
   logic                     nValid, nTimeout;
   logic                     tmoHit;

   assign cntInc = (&rCnt) ? rCnt : rCnt + 1'b1;
   assign tmoHit = (iTimeout != '0) && (rCnt >= iTimeout);

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      nState     = rState;
      nCnt       = rCnt;
      nHigh      = rHigh;
      nHighOut   = oHighCnt;
      nPeriodOut = oPeriodCnt;
      nValid     = 1'b0;
      nTimeout   = oTimeout;
      if (!iEnable) begin
         nState = IDLE;
         nCnt   = '0;
      end else begin
         unique case (rState)
            IDLE: begin
               nCnt = '0;
               if (rise) begin
                  nState = HIGH;
                  nCnt   = cOne;
               end
            end
            HIGH: begin
               nCnt = cntInc;
               if (tmoHit) begin
                  nTimeout = 1'b1;
                  nState   = IDLE;
                  nCnt     = '0;
               end else if (fall) begin
                  nHigh  = rCnt;
                  nState = LOW;
               end
            end
            LOW: begin
               // A rise wins over a simultaneous timeout, so a period equal to iTimeout still reports.
               if (rise) begin
                  nPeriodOut = rCnt;
                  nHighOut   = rHigh;
                  nValid     = 1'b1;
                  nTimeout   = 1'b0;
                  nCnt       = cOne;
                  nState     = HIGH;
               end else if (tmoHit) begin
                  nTimeout = 1'b1;
                  nState   = IDLE;
                  nCnt     = '0;
               end else begin
                  nCnt = cntInc;
               end
            end
            default: begin
               nState = IDLE;
               nCnt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         rState     <= IDLE;
         rCnt       <= '0;
         rHigh      <= '0;
         oHighCnt   <= '0;
         oPeriodCnt <= '0;
         oValid     <= 1'b0;
         oTimeout   <= 1'b0;
      end else begin
         rState     <= nState;
         rCnt       <= nCnt;
         rHigh      <= nHigh;
         oHighCnt   <= nHighOut;
         oPeriodCnt <= nPeriodOut;
         oValid     <= nValid;
         oTimeout   <= nTimeout;
      end
   end

endmodule

// File: tb/tb_bldcm_pwm_capture.sv
// Directed self-checking bench for bldcm_pwm_capture (default build; glitch test adapts to the filter macro).
module tb_bldcm_pwm_capture;

   localparam int W = 32;

   logic         iClock = 1'b0;
   logic         iReset;
   logic         iEnable;
   logic         iPwm;
   logic [W-1:0] iTimeout;
   logic [W-1:0] oHighCnt;
   logic [W-1:0] oPeriodCnt;
   logic         oValid;
   logic         oTimeout;
   logic         oLevel;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      int unsigned cyc;
      logic [W-1:0] hi;
      logic [W-1:0] per;
   } tRep;

   tRep         reps[$];
   int unsigned cycleNum = 0;

   bldcm_pwm_capture #(
      .pCounterWidth(W),
      .pSyncStages  (2),
      .pFilterLen   (4)
   ) dut (
      .iClock    (iClock),
      .iReset    (iReset),
      .iEnable   (iEnable),
      .iPwm      (iPwm),
      .iTimeout  (iTimeout),
      .oHighCnt  (oHighCnt),
      .oPeriodCnt(oPeriodCnt),
      .oValid    (oValid),
      .oTimeout  (oTimeout),
      .oLevel    (oLevel)
   );

   always #5 iClock = ~iClock;

   always @(posedge iClock) cycleNum <= cycleNum + 1;

   // Every report is logged with the cycle it appeared in.
   always @(negedge iClock) begin
      if (oValid === 1'b1) reps.push_back('{cycleNum, oHighCnt, oPeriodCnt});
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached before the summary");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge iClock);
         #1;
      end
   endtask

   task automatic pwm(input int hi, input int per, input int n);
      for (int p = 0; p < n; p++) begin
         for (int c = 0; c < per; c++) begin
            iPwm = (c < hi);
            step(1);
         end
      end
   endtask

   task automatic settle();
      iPwm    = 1'b0;
      iEnable = 1'b0;
      step(8);
      iEnable = 1'b1;
      reps.delete();
   endtask

   task automatic test_reset();
      iReset   = 1'b1;
      iEnable  = 1'b0;
      iPwm     = 1'b0;
      iTimeout = '0;
      step(3);
      compared++;
      if (oHighCnt !== 0 || oPeriodCnt !== 0 || oValid !== 1'b0 || oTimeout !== 1'b0 || oLevel !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_init: got hi=%0d per=%0d v=%b t=%b l=%b expected all 0",
                  oHighCnt, oPeriodCnt, oValid, oTimeout, oLevel);
      end
      iReset  = 1'b0;
      iEnable = 1'b1;
      step(2);
      pwm(3, 10, 3);
      compared++;
      if (oPeriodCnt !== 10 || oHighCnt !== 3) begin
         mismatched++;
         $display("FAIL reset_pre: got %0d/%0d expected 3/10", oHighCnt, oPeriodCnt);
      end
      iPwm = 1'b1;
      @(posedge iClock);
      #3;
      iReset = 1'b1;
      #1;
      compared++;
      if (oHighCnt !== 0 || oPeriodCnt !== 0 || oValid !== 1'b0 || oTimeout !== 1'b0 || oLevel !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_async: got hi=%0d per=%0d v=%b t=%b l=%b expected all 0",
                  oHighCnt, oPeriodCnt, oValid, oTimeout, oLevel);
      end
      iPwm = 1'b0;
      step(3);
      iReset = 1'b0;
      reps.delete();
      pwm(3, 10, 1);
      compared++;
      if (reps.size() != 0) begin
         mismatched++;
         $display("FAIL reset_first_rise: got %0d reports expected 0", reps.size());
      end
      pwm(3, 10, 1);
      compared++;
      if (reps.size() != 1 || reps[0].hi !== 3 || reps[0].per !== 10) begin
         mismatched++;
         $display("FAIL reset_second_rise: got %0d reports (first %0d/%0d) expected 1 of 3/10",
                  reps.size(), (reps.size() > 0) ? reps[0].hi : 0, (reps.size() > 0) ? reps[0].per : 0);
      end
   endtask

   task automatic test_basic();
      settle();
      pwm(3, 10, 6);
      compared++;
      if (reps.size() != 5) begin
         mismatched++;
         $display("FAIL basic_count: got %0d reports expected 5", reps.size());
      end
      for (int i = 0; i < reps.size(); i++) begin
         compared++;
         if (reps[i].hi !== 3 || reps[i].per !== 10) begin
            mismatched++;
            $display("FAIL basic_rep%0d: got %0d/%0d expected 3/10", i, reps[i].hi, reps[i].per);
         end
         if (i > 0) begin
            compared++;
            if (reps[i].cyc - reps[i-1].cyc != 10) begin
               mismatched++;
               $display("FAIL basic_spacing%0d: got %0d cycles expected 10", i, reps[i].cyc - reps[i-1].cyc);
            end
         end
      end
   endtask

   task automatic test_duty_change();
      int eHi[$]  = '{250, 250, 250, 700, 700};
      int ePer[$] = '{1000, 1000, 500, 1000, 1000};
      settle();
      pwm(250, 1000, 2);
      pwm(250, 500, 1);
      pwm(700, 1000, 3);
      compared++;
      if (reps.size() != eHi.size()) begin
         mismatched++;
         $display("FAIL duty_count: got %0d reports expected %0d", reps.size(), eHi.size());
      end
      for (int i = 0; i < eHi.size() && i < reps.size(); i++) begin
         compared++;
         if (reps[i].hi !== eHi[i] || reps[i].per !== ePer[i]) begin
            mismatched++;
            $display("FAIL duty_rep%0d: got %0d/%0d expected %0d/%0d",
                     i, reps[i].hi, reps[i].per, eHi[i], ePer[i]);
         end
      end
   endtask

   task automatic test_timeout();
      int unsigned lastCyc;
      int          waited;
      iTimeout = 50;
      settle();
      pwm(5, 20, 3);
      iPwm = 1'b0;
      compared++;
      if (reps.size() != 2 || reps[1].hi !== 5 || reps[1].per !== 20 || oTimeout !== 1'b0) begin
         mismatched++;
         $display("FAIL timeout_pre: got %0d reports, timeout=%b expected 2 of 5/20, timeout=0",
                  reps.size(), oTimeout);
      end
      lastCyc = (reps.size() > 0) ? reps[reps.size()-1].cyc : cycleNum;
      waited  = 0;
      while (oTimeout !== 1'b1 && waited < 200) begin
         step(1);
         waited++;
      end
      compared++;
      if (oTimeout !== 1'b1) begin
         mismatched++;
         $display("FAIL timeout_flag: got oTimeout=%b after 200 cycles expected 1", oTimeout);
      end else if (cycleNum - lastCyc != 50) begin
         mismatched++;
         $display("FAIL timeout_delay: got %0d cycles after last rise expected 50", cycleNum - lastCyc);
      end
      compared++;
      if (oHighCnt !== 5 || oPeriodCnt !== 20) begin
         mismatched++;
         $display("FAIL timeout_hold: got %0d/%0d expected 5/20", oHighCnt, oPeriodCnt);
      end
      step(10);
      reps.delete();
      pwm(5, 20, 1);
      compared++;
      if (reps.size() != 0 || oTimeout !== 1'b1) begin
         mismatched++;
         $display("FAIL timeout_one_rise: got %0d reports, timeout=%b expected 0 reports, timeout=1",
                  reps.size(), oTimeout);
      end
      pwm(5, 20, 1);
      compared++;
      if (reps.size() != 1 || oTimeout !== 1'b0 || oHighCnt !== 5 || oPeriodCnt !== 20) begin
         mismatched++;
         $display("FAIL timeout_clear: got %0d reports, timeout=%b, %0d/%0d expected 1 report, timeout=0, 5/20",
                  reps.size(), oTimeout, oHighCnt, oPeriodCnt);
      end
      iTimeout = '0;
   endtask

   task automatic test_boundary();
      iTimeout = 50;
      settle();
      pwm(10, 50, 3);
      iTimeout = '0;
      compared++;
      if (reps.size() != 2) begin
         mismatched++;
         $display("FAIL boundary_count: got %0d reports expected 2", reps.size());
      end
      for (int i = 0; i < reps.size(); i++) begin
         compared++;
         if (reps[i].hi !== 10 || reps[i].per !== 50) begin
            mismatched++;
            $display("FAIL boundary_rep%0d: got %0d/%0d expected 10/50", i, reps[i].hi, reps[i].per);
         end
      end
      compared++;
      if (oTimeout !== 1'b0) begin
         mismatched++;
         $display("FAIL boundary_timeout: got %b expected 0", oTimeout);
      end
   endtask

   task automatic test_enable();
      settle();
      pwm(3, 10, 2);
      iPwm = 1'b1;
      step(3);
      iPwm = 1'b0;
      step(4);
      iEnable = 1'b0;
      step(1);
      compared++;
      if (oValid !== 1'b0 || oHighCnt !== 3 || oPeriodCnt !== 10) begin
         mismatched++;
         $display("FAIL enable_hold: got v=%b %0d/%0d expected v=0 3/10", oValid, oHighCnt, oPeriodCnt);
      end
      iPwm = 1'b1;
      step(8);
      compared++;
      if (oLevel !== 1'b1) begin
         mismatched++;
         $display("FAIL enable_level_hi: got %b expected 1", oLevel);
      end
      iPwm = 1'b0;
      step(8);
      compared++;
      if (oLevel !== 1'b0) begin
         mismatched++;
         $display("FAIL enable_level_lo: got %b expected 0", oLevel);
      end
      iEnable = 1'b1;
      reps.delete();
      pwm(3, 10, 1);
      compared++;
      if (reps.size() != 0) begin
         mismatched++;
         $display("FAIL enable_discard: got %0d reports expected 0", reps.size());
      end
      pwm(3, 10, 1);
      compared++;
      if (reps.size() != 1 || oHighCnt !== 3 || oPeriodCnt !== 10) begin
         mismatched++;
         $display("FAIL enable_resume: got %0d reports %0d/%0d expected 1 of 3/10",
                  reps.size(), oHighCnt, oPeriodCnt);
      end
   endtask

   task automatic test_glitch();
`ifdef BLDCM_PWMCAP_FILTER_EN
      int eHi[$]  = '{10, 10};
      int ePer[$] = '{40, 40};
`else
      int eHi[$]  = '{10, 2, 10, 2, 10};
      int ePer[$] = '{20, 20, 20, 20, 20};
`endif
      settle();
      for (int p = 0; p < 3; p++) begin
         for (int c = 0; c < 40; c++) begin
            iPwm = (c < 10) || (c == 20) || (c == 21);
            step(1);
         end
      end
      iPwm = 1'b0;
      compared++;
      if (reps.size() != eHi.size()) begin
         mismatched++;
         $display("FAIL glitch_count: got %0d reports expected %0d", reps.size(), eHi.size());
      end
      for (int i = 0; i < eHi.size() && i < reps.size(); i++) begin
         compared++;
         if (reps[i].hi !== eHi[i] || reps[i].per !== ePer[i]) begin
            mismatched++;
            $display("FAIL glitch_rep%0d: got %0d/%0d expected %0d/%0d",
                     i, reps[i].hi, reps[i].per, eHi[i], ePer[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_duty_change();
      test_timeout();
      test_boundary();
      test_enable();
      test_glitch();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
